rx_uart_frame_ctrl: RTL and testbench

//  Sequencer between the UART RX byte selector and the LED register bank. Parses framed commands
//  [SOF][CMD][LEN][DATA x LEN][CSUM] from the byte stream, buffers the payload and commits it as

---
 rtl/rx_uart_pkg.sv | 21 ++
 rtl/rx_uart_timeout_ctr.sv | 28 ++
 rtl/rx_uart_frame_ctrl.sv | 170 +++++++++++++++++
 tb/tb_rx_uart_frame_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_uart_pkg.sv
// Shared types and constants for the UART RX frame sequencer.
package rx_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_LEN,
    ST_DATA,
    ST_CSUM,
    ST_COMMIT
  } state_t;

  localparam logic [3:0] OPC_WRITE   = 4'h1;
  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Saturating increment for the rejected-frame counter
  function automatic logic [7:0] sat_inc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/rx_uart_timeout_ctr.sv
// Loadable down-counter: reloads on clear, counts while enabled, flags when it reaches zero.
module rx_uart_timeout_ctr #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (CYCLES > 2) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LOAD = CNT_W'(CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_reg <= LOAD;
    end else if (enable && count_reg != '0) begin
      count_reg <= count_reg - ONE;
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/rx_uart_frame_ctrl.sv
// Parses [SOF][CMD][LEN][DATA x LEN][CSUM] frames and replays the payload as register
// writes only once the XOR checksum has been verified.
module rx_uart_frame_ctrl
  import rx_uart_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE       = SOF_DEFAULT,
  parameter int unsigned MAX_LEN        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter int unsigned ADDR_W         = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_byte_valid,
  output logic              out_wr_en,
  output logic [ADDR_W-1:0] out_wr_addr,
  output logic [7:0]        out_wr_data,
  output logic              out_frame_done,
  output logic              out_frame_err,
  output logic              out_busy,
  output logic [7:0]        out_err_count
);

  localparam int IDX_W     = $clog2(MAX_LEN + 1);
  localparam int BUF_AW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int BUF_DEPTH = 1 << BUF_AW;
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  state_t            state_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [IDX_W-1:0]  len_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [7:0]        csum_reg;
  logic [7:0]        payload_reg [BUF_DEPTH];

  logic              wr_en_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic              done_reg;
  logic              err_reg;
  logic              busy_reg;
  logic [7:0]        err_count_reg;

  logic in_frame;
  logic expired;
  logic reject;

  assign in_frame = (state_reg == ST_CMD) || (state_reg == ST_LEN) ||
                    (state_reg == ST_DATA) || (state_reg == ST_CSUM);

  // Every byte reloads the timer; a byte arriving on the expiry cycle therefore wins
  rx_uart_timeout_ctr #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (in_byte_valid),
    .enable (in_frame),
    .expired(expired)
  );

  always_comb begin
    reject = 1'b0;
    if (in_frame) begin
      if (in_byte_valid) begin
        case (state_reg)
          ST_CMD:  reject = (in_byte[7:4] != OPC_WRITE);
          ST_LEN:  reject = (in_byte == 8'd0) || (in_byte > MAX_LEN_B);
          ST_CSUM: reject = (in_byte != csum_reg);
          default: reject = 1'b0;
        endcase
      end else begin
        reject = expired;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      len_reg       <= '0;
      addr_reg      <= '0;
      csum_reg      <= '0;
      wr_en_reg     <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
      busy_reg      <= 1'b0;
      err_count_reg <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) payload_reg[i] <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      if (reject) begin
        state_reg     <= ST_IDLE;
        busy_reg      <= 1'b0;
        err_reg       <= 1'b1;
        err_count_reg <= sat_inc(err_count_reg);
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (in_byte_valid && in_byte == SOF_BYTE) begin
              state_reg <= ST_CMD;
              busy_reg  <= 1'b1;
            end
          end
          ST_CMD: begin
            if (in_byte_valid) begin
              state_reg <= ST_LEN;
              addr_reg  <= ADDR_W'(in_byte[3:0]);
              csum_reg  <= in_byte;
            end
          end
          ST_LEN: begin
            if (in_byte_valid) begin
              state_reg <= ST_DATA;
              len_reg   <= in_byte[IDX_W-1:0];
              csum_reg  <= csum_reg ^ in_byte;
              idx_reg   <= '0;
            end
          end
          ST_DATA: begin
            if (in_byte_valid) begin
              payload_reg[idx_reg[BUF_AW-1:0]] <= in_byte;
              csum_reg <= csum_reg ^ in_byte;
              idx_reg  <= idx_reg + IDX_ONE;
              if (idx_reg == len_reg - IDX_ONE) state_reg <= ST_CSUM;
            end
          end
          ST_CSUM: begin
            if (in_byte_valid) begin
              state_reg <= ST_COMMIT;
              idx_reg   <= '0;
            end
          end
          ST_COMMIT: begin
            // Incoming bytes are ignored here; one write per cycle, then the done pulse
            if (idx_reg == len_reg) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= addr_reg + ADDR_W'(idx_reg);
              wr_data_reg <= payload_reg[idx_reg[BUF_AW-1:0]];
              idx_reg     <= idx_reg + IDX_ONE;
            end
          end
          default: begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_wr_en      = wr_en_reg;
  assign out_wr_addr    = wr_addr_reg;
  assign out_wr_data    = wr_data_reg;
  assign out_frame_done = done_reg;
  assign out_frame_err  = err_reg;
  assign out_busy       = busy_reg;
  assign out_err_count  = err_count_reg;

endmodule

// File: tb/tb_rx_uart_frame_ctrl.sv
// Scenario bench for the frame sequencer: expected writes are queued as frames are sent
// and popped by a monitor whenever the design issues a write.
module tb_rx_uart_frame_ctrl;

  localparam int TO      = 40;
  localparam int MAX_LEN = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_byte;
  logic       in_byte_valid;
  logic       out_wr_en;
  logic [3:0] out_wr_addr;
  logic [7:0] out_wr_data;
  logic       out_frame_done;
  logic       out_frame_err;
  logic       out_busy;
  logic [7:0] out_err_count;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        exp_q[$];
  int         n_pass = 0;
  int         n_total = 0;
  int         wr_seen = 0;
  int         done_seen = 0;
  int         err_seen = 0;
  logic [7:0] exp_err = 8'd0;
  logic [7:0] tx_data [16];

  rx_uart_frame_ctrl #(
    .SOF_BYTE      (8'hA5),
    .MAX_LEN       (MAX_LEN),
    .TIMEOUT_CYCLES(TO),
    .ADDR_W        (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_byte       (in_byte),
    .in_byte_valid (in_byte_valid),
    .out_wr_en     (out_wr_en),
    .out_wr_addr   (out_wr_addr),
    .out_wr_data   (out_wr_data),
    .out_frame_done(out_frame_done),
    .out_frame_err (out_frame_err),
    .out_busy      (out_busy),
    .out_err_count (out_err_count)
  );

  always #5 clk = ~clk;

  // Write scoreboard and pulse bookkeeping
  always @(negedge clk) begin
    wr_t got;
    wr_t want;
    if (out_wr_en === 1'b1) begin
      wr_seen++;
      got = '{addr: out_wr_addr, data: out_wr_data};
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got addr=%h data=%h, required no write", got.addr, got.data);
      end else begin
        want = exp_q.pop_front();
        if (got !== want)
          $display("FAIL write: got addr=%h data=%h, required addr=%h data=%h",
                   got.addr, got.data, want.addr, want.data);
        else n_pass++;
      end
      $display("write addr=%h data=%h", got.addr, got.data);
    end
    if (out_frame_done === 1'b1) done_seen++;
    if (out_frame_err === 1'b1) err_seen++;
    if (out_frame_done === 1'b1 || out_frame_err === 1'b1) begin
      n_total++;
      if (out_frame_done === 1'b1 && out_frame_err === 1'b1)
        $display("FAIL done_err_exclusive: got done=1 err=1, required at most one");
      else n_pass++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_byte       = b;
    in_byte_valid = 1'b1;
    @(negedge clk);
    in_byte_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input int n,
                            input logic [7:0] flip, input bit expect_ok);
    logic [7:0] cs;
    logic [3:0] a;
    cs = cmd ^ len;
    send_byte(8'hA5);
    send_byte(cmd);
    send_byte(len);
    for (int i = 0; i < n; i++) begin
      cs = cs ^ tx_data[i];
      send_byte(tx_data[i]);
    end
    if (expect_ok) begin
      for (int i = 0; i < n; i++) begin
        a = cmd[3:0] + 4'(i);
        exp_q.push_back('{addr: a, data: tx_data[i]});
      end
    end
    send_byte(cs ^ flip);
    $display("frame cmd=%h len=%h n=%0d csum=%h", cmd, len, n, cs ^ flip);
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (out_busy === 1'b1 && i < 100) begin
      @(negedge clk);
      i++;
    end
    n_total++;
    if (out_busy !== 1'b0) $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", tag, out_busy, i);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_byte = 8'h00;
    in_byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({out_wr_en, out_wr_addr, out_wr_data, out_frame_done, out_frame_err, out_busy, out_err_count} !== '0)
      $display("FAIL reset_outputs: got wr=%b a=%h d=%h done=%b err=%b busy=%b cnt=%h, required all 0",
               out_wr_en, out_wr_addr, out_wr_data, out_frame_done, out_frame_err, out_busy, out_err_count);
    else n_pass++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame;
    tx_data[0] = 8'h5A;
    tx_data[1] = 8'h3C;
    send_frame(8'h13, 8'h02, 2, 8'h00, 1'b1);
    n_total++;
    if (out_wr_en !== 1'b0 || out_busy !== 1'b1) $display("FAIL latency_n: got wr=%b busy=%b, required wr=0 busy=1", out_wr_en, out_busy);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({out_wr_en, out_wr_addr, out_wr_data} !== {1'b1, 4'h3, 8'h5A})
      $display("FAIL latency_n1: got wr=%b a=%h d=%h, required 1 3 5a", out_wr_en, out_wr_addr, out_wr_data);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({out_wr_en, out_wr_addr, out_wr_data} !== {1'b1, 4'h4, 8'h3C})
      $display("FAIL latency_n2: got wr=%b a=%h d=%h, required 1 4 3c", out_wr_en, out_wr_addr, out_wr_data);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({out_wr_en, out_frame_done, out_frame_err} !== 3'b010)
      $display("FAIL done_pulse: got wr=%b done=%b err=%b, required 0 1 0", out_wr_en, out_frame_done, out_frame_err);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if ({out_frame_done, out_busy, out_err_count} !== 10'd0)
      $display("FAIL after_done: got done=%b busy=%b cnt=%h, required 0 0 00", out_frame_done, out_busy, out_err_count);
    else n_pass++;
  endtask

  task automatic test_bad_csum;
    int e0, w0, d0;
    e0 = err_seen; w0 = wr_seen; d0 = done_seen;
    send_frame(8'h13, 8'h02, 2, 8'h01, 1'b0);
    exp_err = 8'd1;
    wait_idle("bad_csum");
    n_total++;
    if (err_seen != e0 + 1 || wr_seen != w0 || out_err_count !== exp_err)
      $display("FAIL bad_csum: got errs=%0d writes=%0d cnt=%h, required errs=%0d writes=%0d cnt=%h",
               err_seen - e0, wr_seen - w0, out_err_count, 1, 0, exp_err);
    else n_pass++;
    send_frame(8'h13, 8'h02, 2, 8'h00, 1'b1);
    wait_idle("retry");
    n_total++;
    if (done_seen != d0 + 1 || wr_seen != w0 + 2 || exp_q.size() != 0)
      $display("FAIL retry: got dones=%0d writes=%0d pending=%0d, required 1 2 0",
               done_seen - d0, wr_seen - w0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_wrap_and_len;
    int e0, w0;
    tx_data[0] = 8'h11; tx_data[1] = 8'h22; tx_data[2] = 8'h33;
    send_frame(8'h1F, 8'h03, 3, 8'h00, 1'b1);
    wait_idle("wrap");
    n_total++;
    if (exp_q.size() != 0) $display("FAIL wrap: got pending=%0d, required 0", exp_q.size());
    else n_pass++;
    e0 = err_seen; w0 = wr_seen;
    send_frame(8'h13, 8'h00, 0, 8'h00, 1'b0);
    wait_idle("len0");
    send_frame(8'h13, 8'(MAX_LEN + 1), 0, 8'h00, 1'b0);
    wait_idle("len_max1");
    exp_err = 8'd3;
    n_total++;
    if (err_seen != e0 + 2 || wr_seen != w0 || out_err_count !== exp_err)
      $display("FAIL len_bounds: got errs=%0d writes=%0d cnt=%h, required 2 0 %h",
               err_seen - e0, wr_seen - w0, out_err_count, exp_err);
    else n_pass++;
    tx_data[0] = 8'hA5;
    send_frame(8'h12, 8'h01, 1, 8'h00, 1'b1);
    wait_idle("sof_data");
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sof_data: got pending=%0d, required 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_opcode_timeout;
    int e0, d0, first;
    e0 = err_seen;
    send_byte(8'hA5);
    send_byte(8'h23);
    wait_idle("opcode");
    exp_err = 8'd4;
    n_total++;
    if (err_seen != e0 + 1 || out_err_count !== exp_err)
      $display("FAIL bad_opcode: got errs=%0d cnt=%h, required 1 %h", err_seen - e0, out_err_count, exp_err);
    else n_pass++;
    send_byte(8'hA5);
    send_byte(8'h13);
    first = -1;
    for (int i = 1; i <= TO + 5; i++) begin
      @(negedge clk);
      if (out_frame_err === 1'b1 && first < 0) first = i;
    end
    exp_err = 8'd5;
    n_total++;
    if (first != TO || out_busy !== 1'b0 || out_err_count !== exp_err)
      $display("FAIL timeout: got err at %0d busy=%b cnt=%h, required err at %0d busy=0 cnt=%h",
               first, out_busy, out_err_count, TO, exp_err);
    else n_pass++;
    e0 = err_seen; d0 = done_seen;
    send_byte(8'hA5);
    send_byte(8'h13);
    repeat (TO - 2) @(negedge clk);
    send_byte(8'h01);
    tx_data[0] = 8'hC3;
    exp_q.push_back('{addr: 4'h3, data: 8'hC3});
    send_byte(8'hC3);
    send_byte(8'h13 ^ 8'h01 ^ 8'hC3);
    wait_idle("expiry_byte");
    n_total++;
    if (err_seen != e0 || done_seen != d0 + 1 || exp_q.size() != 0)
      $display("FAIL expiry_byte: got errs=%0d dones=%0d pending=%0d, required 0 1 0",
               err_seen - e0, done_seen - d0, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_commit_drop;
    tx_data[0] = 8'hAA; tx_data[1] = 8'h55;
    send_frame(8'h16, 8'h02, 2, 8'h00, 1'b1);
    send_byte(8'hA5);
    wait_idle("commit_drop");
    repeat (2) @(negedge clk);
    n_total++;
    if (out_busy !== 1'b0 || exp_q.size() != 0)
      $display("FAIL commit_drop: got busy=%b pending=%0d, required 0 0", out_busy, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_commit;
    int w0, d0;
    for (int i = 0; i < 8; i++) tx_data[i] = 8'(8'h40 + i);
    send_frame(8'h10, 8'h08, 8, 8'h00, 1'b1);
    w0 = wr_seen; d0 = done_seen;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_total++;
    if ({out_wr_en, out_wr_addr, out_wr_data, out_frame_done, out_frame_err, out_busy, out_err_count} !== '0)
      $display("FAIL rst_commit_outputs: got wr=%b a=%h d=%h done=%b err=%b busy=%b cnt=%h, required all 0",
               out_wr_en, out_wr_addr, out_wr_data, out_frame_done, out_frame_err, out_busy, out_err_count);
    else n_pass++;
    rst = 1'b0;
    exp_q.delete();
    exp_err = 8'd0;
    repeat (12) @(negedge clk);
    n_total++;
    if (wr_seen - w0 > 2 || done_seen != d0)
      $display("FAIL rst_commit_abort: got writes=%0d dones=%0d, required <=2 and 0", wr_seen - w0, done_seen - d0);
    else n_pass++;
  endtask

  task automatic test_saturate_and_junk;
    int e0;
    e0 = err_seen;
    for (int k = 0; k < 256; k++) begin
      send_byte(8'hA5);
      send_byte(8'h23);
      exp_err = (exp_err == 8'hFF) ? exp_err : exp_err + 8'd1;
    end
    repeat (2) @(negedge clk);
    n_total++;
    if (out_err_count !== exp_err || err_seen != e0 + 256)
      $display("FAIL saturate: got cnt=%h errs=%0d, required cnt=%h errs=256", out_err_count, err_seen - e0, exp_err);
    else n_pass++;
    e0 = err_seen;
    send_byte(8'h00);
    send_byte(8'hFF);
    @(negedge clk);
    n_total++;
    if (out_busy !== 1'b0 || err_seen != e0 || out_err_count !== 8'hFF)
      $display("FAIL junk: got busy=%b errs=%0d cnt=%h, required 0 0 ff", out_busy, err_seen - e0, out_err_count);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_bad_csum();
    test_wrap_and_len();
    test_opcode_timeout();
    test_commit_drop();
    test_reset_mid_commit();
    test_saturate_and_junk();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
